// File: rtl/modular_add_sub_unit.sv
// Two-pass modular adder/subtractor: one shared carry-lookahead adder computes the raw
// add/sub, then the modulus correction, selecting the in-range result from the carries.
module modular_add_sub_unit #(
   parameter int unsigned DATA_WIDTH = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  i_op,
   input  logic [DATA_WIDTH-1:0] in_1,
   input  logic [DATA_WIDTH-1:0] in_2,
   input  logic [DATA_WIDTH-1:0] i_mod,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] o_Result
);

   localparam int GroupW    = 4;
   localparam int NumGroups = (int'(DATA_WIDTH) + GroupW - 1) / GroupW;

   typedef enum logic [1:0] {StIdle, StPass1, StPass2, StDone} state_e;

   state_e                state_q, state_d;
   logic                  op_q;
   logic [DATA_WIDTH-1:0] a_q, b_q, p_q, t_q, result_q, result_d;
   logic                  c1_q;

   logic [DATA_WIDTH-1:0] cla_a, cla_b, cla_sum, cla_g, cla_p;
   logic                  cla_cin, cla_cout;
   logic                  grp_c, grp_g, grp_p, bit_c;

   // Operand steering for the shared adder: pass 1 forms A +/- B, pass 2 applies -P or +P.
   always_comb begin
      cla_a   = t_q;
      cla_b   = op_q ? p_q : ~p_q;
      cla_cin = ~op_q;
      if (state_q == StPass1) begin
         cla_a   = a_q;
         cla_b   = op_q ? ~b_q : b_q;
         cla_cin = op_q;
      end
   end

   assign cla_g = cla_a & cla_b;
   assign cla_p = cla_a ^ cla_b;

   // Block carry-lookahead: group generate/propagate feed the next group's carry-in directly.
   always_comb begin
      cla_sum = '0;
      grp_c   = cla_cin;
      grp_g   = 1'b0;
      grp_p   = 1'b1;
      bit_c   = 1'b0;
      for (int gi = 0; gi < NumGroups; gi++) begin
         bit_c = grp_c;
         grp_g = 1'b0;
         grp_p = 1'b1;
         for (int b = 0; b < GroupW; b++) begin
            if (gi * GroupW + b < int'(DATA_WIDTH)) begin
               cla_sum[gi*GroupW+b] = cla_p[gi*GroupW+b] ^ bit_c;
               bit_c = cla_g[gi*GroupW+b] | (cla_p[gi*GroupW+b] & bit_c);
               grp_g = cla_g[gi*GroupW+b] | (cla_p[gi*GroupW+b] & grp_g);
               grp_p = grp_p & cla_p[gi*GroupW+b];
            end
         end
         grp_c = grp_g | (grp_p & grp_c);
      end
      cla_cout = grp_c;
   end

   // Add: any carry means T (plus overflow) reached P, so take T-P.
   // Sub: c1 set means no borrow, so T is already in range; otherwise take T+P.
   always_comb begin
      if (op_q) begin
         result_d = c1_q ? t_q : cla_sum;
      end else begin
         result_d = (c1_q | cla_cout) ? cla_sum : t_q;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (in_valid) state_d = StPass1;
         StPass1: state_d = StPass2;
         StPass2: state_d = StDone;
         StDone:  if (out_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         op_q     <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         p_q      <= '0;
         t_q      <= '0;
         c1_q     <= 1'b0;
         result_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == StIdle && in_valid) begin
            op_q <= i_op;
            a_q  <= in_1;
            b_q  <= in_2;
            p_q  <= i_mod;
         end
         if (state_q == StPass1) begin
            t_q  <= cla_sum;
            c1_q <= cla_cout;
         end
         if (state_q == StPass2) begin
            result_q <= result_d;
         end
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign o_Result  = result_q;

endmodule

// File: tb/tb_modular_add_sub_unit.sv
// Directed and random checks of modular_add_sub_unit over the secp256k1 field prime.
module tb_modular_add_sub_unit;

   localparam int W = 256;
   localparam logic [W-1:0] P =
      256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
   localparam logic [W-1:0] P_M1 =
      256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2E;
   localparam logic [W-1:0] P_M2 =
      256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2D;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic         i_op = 1'b0;
   logic [W-1:0] in_1 = '0;
   logic [W-1:0] in_2 = '0;
   logic [W-1:0] i_mod = P;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] o_Result;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   modular_add_sub_unit #(.DATA_WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .i_op     (i_op),
      .in_1     (in_1),
      .in_2     (in_2),
      .i_mod    (i_mod),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .o_Result (o_Result)
   );

   // Stimulus only: called at a negedge with the DUT idle, returns at a negedge with it idle.
   task automatic run_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int stall, output logic [W-1:0] res, output bit ok);
      int n;
      ok  = 1'b0;
      res = '0;
      in_valid = 1'b1;
      i_op = op;
      in_1 = a;
      in_2 = b;
      i_mod = P;
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (out_valid !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (out_valid === 1'b1) begin
         ok = 1'b1;
         repeat (stall) @(negedge clk);
         res = o_Result;
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b1;
      in_1 = 5;
      in_2 = 7;
      repeat (3) @(negedge clk);
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_out_valid: got %b want 0", out_valid);
      end
      vectors++;
      if (o_Result !== '0) begin
         miscompares++;
         $display("FAIL reset_result: got %h want 0", o_Result);
      end
      rst = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_no_accept: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
      end
   endtask

   task automatic test_latency();
      int lat;
      in_valid = 1'b1;
      i_op = 1'b0;
      in_1 = 5;
      in_2 = 7;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      vectors++;
      if (lat != 3) begin
         miscompares++;
         $display("FAIL latency: got %0d cycles want 3", lat);
      end
      vectors++;
      if (o_Result !== 256'd12) begin
         miscompares++;
         $display("FAIL add_5_7: got %h want c", o_Result);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL latency_release: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
      end
   endtask

   task automatic test_directed();
      logic         ops  [9];
      logic [W-1:0] as   [9];
      logic [W-1:0] bs   [9];
      logic [W-1:0] exps [9];
      logic [W-1:0] got;
      bit           ok;
      ops[0] = 0; as[0] = P_M1; bs[0] = 2;    exps[0] = 1;
      ops[1] = 0; as[1] = P_M1; bs[1] = 1;    exps[1] = 0;
      ops[2] = 0; as[2] = P_M1; bs[2] = P_M1; exps[2] = P_M2;
      ops[3] = 0; as[3] = 0;    bs[3] = 0;    exps[3] = 0;
      ops[4] = 1; as[4] = 7;    bs[4] = 5;    exps[4] = 2;
      ops[5] = 1; as[5] = 0;    bs[5] = 1;    exps[5] = P_M1;
      ops[6] = 1; as[6] = P_M1; bs[6] = P_M1; exps[6] = 0;
      ops[7] = 1; as[7] = 0;    bs[7] = 0;    exps[7] = 0;
      ops[8] = 1; as[8] = 3;    bs[8] = 10;   exps[8] = P - 256'd7;
      for (int i = 0; i < 9; i++) begin
         run_op(ops[i], as[i], bs[i], i % 3, got, ok);
         vectors++;
         if (!ok || got !== exps[i]) begin
            miscompares++;
            $display("FAIL directed_%0d op=%b: got %h (done=%b) want %h",
                     i, ops[i], got, ok, exps[i]);
         end
      end
   endtask

   task automatic test_stall();
      int n;
      bit stable;
      in_valid = 1'b1;
      i_op = 1'b0;
      in_1 = 100;
      in_2 = 200;
      @(negedge clk);
      in_1 = 1;
      in_2 = 1;
      n = 0;
      while (out_valid !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      stable = 1'b1;
      for (int c = 0; c < 10; c++) begin
         if (out_valid !== 1'b1 || o_Result !== 256'd300 || in_ready !== 1'b0) stable = 1'b0;
         @(negedge clk);
      end
      vectors++;
      if (!stable) begin
         miscompares++;
         $display("FAIL stall_hold: out_valid=%b in_ready=%b result=%h want 1/0/12c",
                  out_valid, in_ready, o_Result);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      vectors++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL stall_release: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
      end
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL stall_ghost_op: in_ready=%b want 1", in_ready);
      end
   endtask

   task automatic test_reset_mid_op();
      logic [W-1:0] got;
      bit           ok;
      bit           spurious;
      in_valid = 1'b1;
      i_op = 1'b1;
      in_1 = 7;
      in_2 = 5;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      vectors++;
      if (out_valid !== 1'b0 || o_Result !== '0 || in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_mid_op: out_valid=%b in_ready=%b result=%h want 0/1/0",
                  out_valid, in_ready, o_Result);
      end
      spurious = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (out_valid !== 1'b0) spurious = 1'b1;
      end
      vectors++;
      if (spurious) begin
         miscompares++;
         $display("FAIL reset_discard: got out_valid=1 want 0");
      end
      run_op(1'b0, P_M1, 256'd2, 0, got, ok);
      vectors++;
      if (!ok || got !== 256'd1) begin
         miscompares++;
         $display("FAIL after_reset_op: got %h (done=%b) want 1", got, ok);
      end
   endtask

   task automatic test_random();
      logic [W-1:0] a, b, exp, got;
      logic [W:0]   s;
      logic         op;
      bit           ok;
      int           stall;
      for (int n = 0; n < 10000; n++) begin
         for (int k = 0; k < W / 32; k++) begin
            a[k*32 +: 32] = $urandom;
            b[k*32 +: 32] = $urandom;
         end
         while (a >= P) a = a - P;
         while (b >= P) b = b - P;
         op = 1'($urandom_range(0, 1));
         stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
         if (!op) begin
            s = {1'b0, a} + {1'b0, b};
            if (s >= {1'b0, P}) s = s - {1'b0, P};
            exp = s[W-1:0];
         end else if (a >= b) begin
            exp = a - b;
         end else begin
            exp = a + (P - b);
         end
         run_op(op, a, b, stall, got, ok);
         vectors++;
         if (!ok || got !== exp) begin
            miscompares++;
            $display("FAIL random_%0d op=%b a=%h b=%h: got %h (done=%b) want %h",
                     n, op, a, b, got, ok, exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_directed();
      test_stall();
      test_reset_mid_op();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
